alu_arbiter: RTL and testbench

Shares the single combinational ALU between two requesters (port 0: execute stage, port 1: branch/compare unit) using round-robin arbitration and a valid/ready request handshake. It registers the granted operands, drives the ALU from those registers, and stretches multiply/divide operations over a programmable number of settle cycles. It returns the captured result and branch flag to the winning requester. It sits between the pipeline control logic and the ALU instance.

---
 rtl/alu_arbiter_if.sv | 61 ++++++
 rtl/alu_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_alu_arbiter.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: bundles the two requester handshakes, the shared response
// bus and the ALU connection of the ALU arbiter.
//   slave  : arbiter view (takes requests, drives responses and ALU operands)
//   master : environment view (requesters plus the combinational ALU)
// Handshake: a request transfers on the rising clock edge where
// reqN_valid && reqN_ready are both high. A requester keeps valid and its
// operands stable until that edge. Responses are single-cycle rspN_valid
// pulses with no backpressure; rsp_result/rsp_zero/rsp_err are valid in the
// pulse cycle and hold until the next capture.
interface alu_arbiter_if #(
  parameter int WIDTH = 32
);
  // Port 0 (execute stage) request
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [3:0]       req0_ctrl;
  logic [4:0]       req0_shamt;
  logic [2:0]       req0_btype;
  // Port 1 (branch/compare unit) request
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [3:0]       req1_ctrl;
  logic [4:0]       req1_shamt;
  logic [2:0]       req1_btype;
  // Shared response bus
  logic             rsp0_valid;
  logic             rsp1_valid;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;
  logic             rsp_err;
  // ALU connection
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_ctrl;
  logic [4:0]       alu_shamt;
  logic [2:0]       alu_btype;
  logic [WIDTH-1:0] alu_out;
  logic             alu_zero;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_ctrl, req0_shamt, req0_btype,
    input  req1_valid, req1_a, req1_b, req1_ctrl, req1_shamt, req1_btype,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_result, rsp_zero, rsp_err,
    output alu_a, alu_b, alu_ctrl, alu_shamt, alu_btype,
    input  alu_out, alu_zero
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_ctrl, req0_shamt, req0_btype,
    output req1_valid, req1_a, req1_b, req1_ctrl, req1_shamt, req1_btype,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_result, rsp_zero, rsp_err,
    input  alu_a, alu_b, alu_ctrl, alu_shamt, alu_btype,
    output alu_out, alu_zero
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters with
// round-robin arbitration. Granted operands are registered and drive the ALU;
// mul/div results are captured after MULDIV_LAT settle cycles; divide by zero
// bypasses the ALU and returns all-ones with rsp_err set.
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   bus          alu_arbiter_if.slave (requests, responses, ALU connection)
//   dbg_state_o  current FSM state (0 IDLE, 1 EXEC, 2 WAIT, 3 RESP)
// MULDIV_LAT must be >= 1.
module alu_arbiter #(
  parameter int WIDTH      = 32,
  parameter int MULDIV_LAT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus,
  output logic [1:0]    dbg_state_o
);

  localparam int CW = $clog2(MULDIV_LAT + 1);

  localparam logic [3:0] CTRL_MUL = 4'b0010;
  localparam logic [3:0] CTRL_DIV = 4'b0011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic [4:0]       shamt_q, shamt_d;
  logic [2:0]       btype_q, btype_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;

  logic             grant_sel;
  logic             accept;
  logic             is_muldiv;
  logic             div_by_zero;

  // Winner: the only valid port, or under contention the port that was not
  // granted last. last_grant resets to 1 so port 0 wins the first contention.
  // Ready is gated with rst_n so no grant is visible while reset is held.
  always_comb begin
    grant_sel = (bus.req0_valid && bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
    accept    = rst_n && (state_q == IDLE) && (bus.req0_valid || bus.req1_valid);
  end

  assign bus.req0_ready = accept && !grant_sel;
  assign bus.req1_ready = accept &&  grant_sel;

  assign is_muldiv   = (ctrl_q == CTRL_MUL) || (ctrl_q == CTRL_DIV);
  assign div_by_zero = (ctrl_q == CTRL_DIV) && (b_q == '0);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    ctrl_d       = ctrl_q;
    shamt_d      = shamt_q;
    btype_d      = btype_q;
    result_d     = result_q;
    zero_d       = zero_q;
    err_d        = err_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d      = EXEC;
          last_grant_d = ~last_grant_q;
          owner_d      = grant_sel;
          if (grant_sel) begin
            a_d     = bus.req1_a;
            b_d     = bus.req1_b;
            ctrl_d  = bus.req1_ctrl;
            shamt_d = bus.req1_shamt;
            btype_d = bus.req1_btype;
          end else begin
            a_d     = bus.req0_a;
            b_d     = bus.req0_b;
            ctrl_d  = bus.req0_ctrl;
            shamt_d = bus.req0_shamt;
            btype_d = bus.req0_btype;
          end
        end
      end
      EXEC: begin
        if (div_by_zero) begin
          result_d = '1;
          zero_d   = 1'b0;
          err_d    = 1'b1;
          state_d  = RESP;
        end else if (is_muldiv) begin
          // WAIT spends MULDIV_LAT cycles: counts MULDIV_LAT-1 down to 0.
          cnt_d   = CW'(MULDIV_LAT - 1);
          state_d = WAIT;
        end else begin
          result_d = bus.alu_out;
          zero_d   = bus.alu_zero;
          err_d    = 1'b0;
          state_d  = RESP;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          result_d = bus.alu_out;
          zero_d   = bus.alu_zero;
          err_d    = 1'b0;
          state_d  = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      ctrl_q       <= '0;
      shamt_q      <= '0;
      btype_q      <= '0;
      result_q     <= '0;
      zero_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      ctrl_q       <= ctrl_d;
      shamt_q      <= shamt_d;
      btype_q      <= btype_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
      err_q        <= err_d;
    end
  end

  assign bus.rsp0_valid = (state_q == RESP) && !owner_q;
  assign bus.rsp1_valid = (state_q == RESP) &&  owner_q;
  assign bus.rsp_result = result_q;
  assign bus.rsp_zero   = zero_q;
  assign bus.rsp_err    = err_q;

  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_ctrl  = ctrl_q;
  assign bus.alu_shamt = shamt_q;
  assign bus.alu_btype = btype_q;

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench for alu_arbiter with a behavioural ALU and
// a response scoreboard (expected result, flags, owner port and latency).
module tb_alu_arbiter;

  localparam int WIDTH      = 32;
  localparam int MULDIV_LAT = 4;
  localparam int EW         = WIDTH + 3;  // {port, err, zero, result}

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  alu_arbiter_if #(.WIDTH(WIDTH)) bus();
  logic [1:0] dbg_state;

  alu_arbiter #(.WIDTH(WIDTH), .MULDIV_LAT(MULDIV_LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  // ---------------- behavioural ALU ----------------
  // 0000 add, 0001 sub (Zero from btype: 001 beq, 010 bne), 0010 mul,
  // 0011 div, 0100 or, 0101 sll; anything else returns 0.
  always_comb begin
    logic [WIDTH-1:0] r;
    r = '0;
    case (bus.alu_ctrl)
      4'b0000: r = bus.alu_a + bus.alu_b;
      4'b0001: r = bus.alu_a - bus.alu_b;
      4'b0010: r = bus.alu_a * bus.alu_b;
      4'b0011: r = (bus.alu_b != '0) ? bus.alu_a / bus.alu_b : '1;
      4'b0100: r = bus.alu_a | bus.alu_b;
      4'b0101: r = bus.alu_a << bus.alu_shamt;
      default: r = '0;
    endcase
    bus.alu_out = r;
    if (bus.alu_ctrl == 4'b0001 && bus.alu_btype == 3'b001)
      bus.alu_zero = (bus.alu_a == bus.alu_b);
    else if (bus.alu_ctrl == 4'b0001 && bus.alu_btype == 3'b010)
      bus.alu_zero = (bus.alu_a != bus.alu_b);
    else
      bus.alu_zero = (r == '0);
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int            lat_q[$];
  int            acc_q[$];
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fail(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: observed timeout/unexpected event expected handshake", tag);
  endtask

  task automatic push_exp(input bit port, input bit err, input bit zero,
                          input logic [WIDTH-1:0] res, input int lat);
    exp_q.push_back({port, err, zero, res});
    lat_q.push_back(lat);
  endtask

  always @(negedge clk) begin
    logic [EW-1:0] e;
    int            l;
    int            a;
    if (rst_n) begin
      check("ready_onehot", {30'd0, bus.req0_ready && bus.req1_ready}, 0);
      if (acc_q.size() > 0)
        check("ready_busy", {bus.req1_ready, bus.req0_ready}, 0);
      if (bus.rsp0_valid || bus.rsp1_valid) begin
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          fail("rsp_unexpected");
        end else begin
          e = exp_q.pop_front();
          l = lat_q.pop_front();
          a = acc_q.pop_front();
          check("rsp_port",   {bus.rsp1_valid, bus.rsp0_valid}, e[EW-1] ? 2'b10 : 2'b01);
          check("rsp_err",    bus.rsp_err,    e[EW-2]);
          check("rsp_zero",   bus.rsp_zero,   e[EW-3]);
          check("rsp_result", bus.rsp_result, e[WIDTH-1:0]);
          check("rsp_latency", cyc - a, l);
        end
      end
      if (bus.req0_valid && bus.req0_ready) acc_q.push_back(cyc);
      if (bus.req1_valid && bus.req1_ready) acc_q.push_back(cyc);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input bit port, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [3:0] ctrl, input logic [4:0] shamt, input logic [2:0] btype);
    if (port) begin
      bus.req1_a = a; bus.req1_b = b; bus.req1_ctrl = ctrl;
      bus.req1_shamt = shamt; bus.req1_btype = btype; bus.req1_valid = 1'b1;
    end else begin
      bus.req0_a = a; bus.req0_b = b; bus.req0_ctrl = ctrl;
      bus.req0_shamt = shamt; bus.req0_btype = btype; bus.req0_valid = 1'b1;
    end
  endtask

  // Raise one request and hold it until accepted; returns #1 after the accept edge.
  task automatic issue(input bit port, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [3:0] ctrl, input logic [4:0] shamt, input logic [2:0] btype);
    bit got = 0;
    set_req(port, a, b, ctrl, shamt, btype);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (port ? bus.req1_ready : bus.req0_ready) begin
        got = 1;
        break;
      end
    end
    if (!got) fail("accept_timeout");
    @(posedge clk);
    #1;
    if (port) bus.req1_valid = 1'b0;
    else      bus.req0_valid = 1'b0;
  endtask

  // Both ports already valid; keep them valid until n accepts have happened.
  task automatic contend(input int n);
    int got = 0;
    for (int i = 0; i < 200 && got < n; i++) begin
      @(negedge clk);
      if (bus.req0_ready || bus.req1_ready) got++;
    end
    if (got != n) fail("contend_timeout");
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0) begin
        done = 1;
        break;
      end
    end
    if (!done) fail("idle_timeout");
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},  {bus.req1_ready, bus.req0_ready}, 0);
    check({tag, "_rspv"},   {bus.rsp1_valid, bus.rsp0_valid}, 0);
    check({tag, "_result"}, bus.rsp_result, 0);
    check({tag, "_flags"},  {bus.rsp_zero, bus.rsp_err}, 0);
    check({tag, "_alu_ab"}, {bus.alu_a, bus.alu_b}, 0);
    check({tag, "_alu_ctl"}, {bus.alu_ctrl, bus.alu_shamt, bus.alu_btype}, 0);
    check({tag, "_state"},  dbg_state, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req0_ctrl = '0; bus.req0_shamt = '0; bus.req0_btype = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
    bus.req1_ctrl = '0; bus.req1_shamt = '0; bus.req1_btype = '0;

    // Contention from reset: both valid, ready must stay low under reset.
    set_req(0, 32'd9,    32'd4,    4'b0001, 5'd0, 3'b000);
    set_req(1, 32'h0F0,  32'h00F,  4'b0100, 5'd0, 3'b000);
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    push_exp(0, 0, 0, 32'd5,  2);
    push_exp(1, 0, 0, 32'hFF, 2);
    push_exp(0, 0, 0, 32'd5,  2);
    push_exp(1, 0, 0, 32'hFF, 2);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    contend(4);
    wait_idle();

    // Single add on port 0.
    push_exp(0, 0, 0, 32'd12, 2);
    issue(0, 32'd5, 32'd7, 4'b0000, 5'd0, 3'b000);
    wait_idle();

    // Multiply on port 1; operand change after accept must not matter.
    push_exp(1, 0, 0, 32'd42, 2 + MULDIV_LAT);
    issue(1, 32'd6, 32'd7, 4'b0010, 5'd0, 3'b000);
    bus.req1_a = 32'd99;
    bus.req1_b = 32'd99;
    #1;
    check("mul_alu_a",    bus.alu_a,    32'd6);
    check("mul_alu_ctrl", bus.alu_ctrl, 4'b0010);
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    check("mul_result_hold", bus.rsp_result, 32'd42);

    // Divide by zero, then a normal divide clears rsp_err.
    push_exp(0, 1, 0, '1, 2);
    issue(0, 32'd100, 32'd0, 4'b0011, 5'd0, 3'b000);
    wait_idle();
    push_exp(0, 0, 0, 32'd20, 2 + MULDIV_LAT);
    issue(0, 32'd100, 32'd5, 4'b0011, 5'd0, 3'b000);
    wait_idle();

    // Branch compare: beq then bne on equal operands.
    push_exp(1, 0, 1, 32'd0, 2);
    issue(1, 32'd3, 32'd3, 4'b0001, 5'd0, 3'b001);
    wait_idle();
    push_exp(1, 0, 0, 32'd0, 2);
    issue(1, 32'd3, 32'd3, 4'b0001, 5'd0, 3'b010);
    wait_idle();

    // Unknown control code, then a shift using shamt.
    push_exp(1, 0, 1, 32'd0, 2);
    issue(1, 32'h1234, 32'h5678, 4'b1111, 5'd0, 3'b000);
    wait_idle();
    push_exp(0, 0, 0, 32'd16, 2);
    issue(0, 32'd1, 32'd0, 4'b0101, 5'd4, 3'b000);
    wait_idle();

    // Reset two cycles into a multiply: abort with no response.
    issue(1, 32'd6, 32'd7, 4'b0010, 5'd0, 3'b000);
    repeat (2) @(posedge clk);
    #1;
    check("pre_reset_state", dbg_state, 2'd2);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    lat_q.delete();
    acc_q.delete();
    check_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("midreset_hold");

    // After release with both ports valid, port 0 wins.
    set_req(0, 32'd10, 32'd1, 4'b0000, 5'd0, 3'b000);
    set_req(1, 32'd20, 32'd2, 4'b0000, 5'd0, 3'b000);
    push_exp(0, 0, 0, 32'd11, 2);
    push_exp(1, 0, 0, 32'd22, 2);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    contend(2);
    wait_idle();

    // Port 1 alone is granted immediately.
    push_exp(1, 0, 0, 32'd15, 2);
    issue(1, 32'd7, 32'd8, 4'b0000, 5'd0, 3'b000);
    wait_idle();

    repeat (4) @(posedge clk);
    #1;
    check("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
